muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller that produces the LO/HI pair consumed by the register bank's mul/div load path.
- Accepts one operation from the decode/control unit and runs it iteratively, one bit per cycle.
- Presents the result on lo/hi and pulses wr_muldiv so the register bank captures LO and HI on that cycle.
- Holds busy so the control unit stalls any HI/LO read until the result is written.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_passo.sv | 33 +++
 rtl/muldiv_sequencer.sv | 152 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Op codes match the decode unit's 2-bit mul/div field.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_passo.sv
// One iteration of the unsigned core: shift-add for multiply, restoring step for divide.
// The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_passo #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_isDiv,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qBit
);

  logic [WIDTH-1:0] w_hiPart;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;

  assign w_hiPart = i_acc[2*WIDTH-1:WIDTH];

  // The quotient bit is returned separately; the divide path leaves bit 0 clear for it.
  always_comb begin
    w_mulSum = {1'b0, w_hiPart} + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
    w_trial  = {w_hiPart, i_acc[WIDTH-1]};
    w_diff   = w_trial - {1'b0, i_operand};
    o_qBit   = ~w_diff[WIDTH];
    if (i_isDiv) begin
      o_acc = {(o_qBit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_mulSum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller feeding the LO/HI write port of the register bank.
// Works on operand magnitudes for WIDTH cycles, then applies the recorded signs in FIX.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr_muldiv,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e r_state;
  state_e w_nextState;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic               r_isDiv;
  logic               r_negLo;
  logic               r_negHi;
  logic               r_zeroPend;
  logic               r_busy;
  logic               r_done;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;

  logic               w_isDiv;
  logic               w_isSigned;
  logic               w_bZero;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [2*WIDTH-1:0] w_stepAcc;
  logic               w_qBit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_isDiv    = (op == OP_DIVU) || (op == OP_DIV);
  assign w_isSigned = (op == OP_MULT) || (op == OP_DIV);
  assign w_bZero    = (b == '0);
  assign w_aMag     = (w_isSigned && a[WIDTH-1]) ? -a : a;
  assign w_bMag     = (w_isSigned && b[WIDTH-1]) ? -b : b;

  assign w_prod = r_negLo ? -r_acc : r_acc;
  assign w_quo  = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  muldiv_passo #(.WIDTH(WIDTH)) u_passo (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_isDiv   (r_isDiv),
    .o_acc     (w_stepAcc),
    .o_qBit    (w_qBit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Divide-by-zero still passes through FIX so its result is written one edge after acceptance.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = (w_isDiv && w_bZero) ? FIX : CALC;
      CALC:    if (r_cnt == '0) w_nextState = FIX;
      FIX:     w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_operand  <= '0;
      r_isDiv    <= 1'b0;
      r_negLo    <= 1'b0;
      r_negHi    <= 1'b0;
      r_zeroPend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_divZero  <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else begin
      r_busy <= (w_nextState == CALC) || (w_nextState == FIX);
      r_done <= (w_nextState == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_isDiv    <= w_isDiv;
            r_cnt      <= CW'(WIDTH - 1);
            r_zeroPend <= w_isDiv && w_bZero;
            r_divZero  <= 1'b0;
            r_negLo    <= w_isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_negHi    <= w_isSigned && a[WIDTH-1];
            if (w_isDiv && w_bZero) begin
              r_acc <= {{WIDTH{1'b0}}, a};
            end else if (w_isDiv) begin
              r_acc     <= {{WIDTH{1'b0}}, w_aMag};
              r_operand <= w_bMag;
            end else begin
              r_acc     <= {{WIDTH{1'b0}}, w_bMag};
              r_operand <= w_aMag;
            end
          end
        end
        CALC: begin
          r_acc <= {w_stepAcc[2*WIDTH-1:1], (r_isDiv ? w_qBit : w_stepAcc[0])};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_zeroPend) begin
            r_lo      <= '1;
            r_hi      <= r_acc[WIDTH-1:0];
            r_divZero <= 1'b1;
          end else if (r_isDiv) begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_muldiv = r_done;
  assign lo        = r_lo;
  assign hi        = r_hi;
  assign div_zero  = r_divZero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases, ignored starts, mid-op reset,
// and randomized back-to-back ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        wr_muldiv;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_zero;

  int nChecks = 0;
  int nFails  = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .wr_muldiv (wr_muldiv),
    .lo        (lo),
    .hi        (hi),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference results straight from integer arithmetic on the full-width values.
  function automatic void refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] eLo, output logic [31:0] eHi,
                                   output logic eDz, output int eLat);
    longint      sx;
    longint      sy;
    longint      p;
    logic [63:0] u;
    eDz  = 1'b0;
    eLat = 33;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    if (o[1] && (y == 32'h0)) begin
      eLo  = 32'hFFFFFFFF;
      eHi  = x;
      eDz  = 1'b1;
      eLat = 1;
    end else begin
      case (o)
        2'b00: begin u = {32'h0, x} * {32'h0, y}; eLo = u[31:0]; eHi = u[63:32]; end
        2'b01: begin p = sx * sy; u = p; eLo = u[31:0]; eHi = u[63:32]; end
        2'b10: begin eLo = x / y; eHi = x % y; end
        default: begin
          p = sx / sy; u = p; eLo = u[31:0];
          p = sx % sy; u = p; eHi = u[31:0];
        end
      endcase
    end
  endfunction

  // Issues one op and waits (bounded) for done; reports edges from acceptance to done.
  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int edges, output logic gotDone, output logic busyOk);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    edges = 0; gotDone = 1'b0; busyOk = 1'b1;
    while (!gotDone && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) gotDone = 1'b1;
      else if (busy !== 1'b1) busyOk = 1'b0;
    end
  endtask

  task automatic test_reset();
    nChecks++;
    if ({busy, done, wr_muldiv, div_zero, lo, hi} !== 68'h0) begin
      nFails++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b wr=%b dz=%b lo=%h hi=%h, expected all 0",
               busy, done, wr_muldiv, div_zero, lo, hi);
    end
  endtask

  logic [1:0]  tOp  [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
  logic [31:0] tA   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000};
  logic [31:0] tB   [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'd7, 32'hFFFFFFFF};
  logic [31:0] tLo  [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'h80000000};
  logic [31:0] tHi  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000064, 32'd2, 32'h0};
  logic        tDz  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int          tLat [6] = '{33, 33, 33, 1, 33, 33};

  task automatic test_directed();
    int   edges;
    logic gotDone;
    logic busyOk;
    for (int i = 0; i < 6; i++) begin
      runOp(tOp[i], tA[i], tB[i], edges, gotDone, busyOk);
      nChecks++;
      if (!gotDone || edges != tLat[i]) begin
        nFails++;
        $display("[TB] FAIL directed%0d_latency: got %0d edges (done=%b), expected %0d", i, edges, gotDone, tLat[i]);
      end
      nChecks++;
      if ({lo, hi, div_zero} !== {tLo[i], tHi[i], tDz[i]}) begin
        nFails++;
        $display("[TB] FAIL directed%0d_result: got lo=%h hi=%h dz=%b, expected lo=%h hi=%h dz=%b",
                 i, lo, hi, div_zero, tLo[i], tHi[i], tDz[i]);
      end
      nChecks++;
      if ({busyOk, wr_muldiv, busy} !== 3'b110) begin
        nFails++;
        $display("[TB] FAIL directed%0d_strobes: got busyOk=%b wr=%b busy=%b, expected 1 1 0", i, busyOk, wr_muldiv, busy);
      end
      @(posedge clk);
      #1;
      nChecks++;
      if ({done, wr_muldiv} !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL directed%0d_pulse_width: got done=%b wr=%b, expected 0 0", i, done, wr_muldiv);
      end
    end
  endtask

  task automatic test_ignored_start();
    int          pulses = 0;
    int          firstEdge = -1;
    logic [31:0] capLo = '0;
    logic [31:0] capHi = '0;
    @(negedge clk);
    op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (firstEdge < 0) begin
          firstEdge = i; capLo = lo; capHi = hi;
          start = 1'b1; op = 2'b10; a = 32'd5; b = 32'd0;
        end
      end
      if (i == 9) begin
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd11;
      end
    end
    nChecks++;
    if (pulses != 1 || firstEdge != 33) begin
      nFails++;
      $display("[TB] FAIL ignored_start_pulses: got %0d pulses first at edge %0d, expected 1 at 33", pulses, firstEdge);
    end
    nChecks++;
    if ({capLo, capHi, lo, hi} !== {32'd42, 32'd0, 32'd42, 32'd0}) begin
      nFails++;
      $display("[TB] FAIL ignored_start_result: got lo=%h hi=%h (now %h %h), expected 2a 0", capLo, capHi, lo, hi);
    end
  endtask

  task automatic test_reset_mid();
    int          pulses = 0;
    int          edges;
    logic        gotDone;
    logic        busyOk;
    logic [31:0] eLo;
    logic [31:0] eHi;
    logic        eDz;
    int          eLat;
    @(negedge clk);
    op = 2'b01; a = 32'hFFFF1234; b = 32'h00005678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    nChecks++;
    if ({busy, done, wr_muldiv, lo, hi} !== 67'h0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_outputs: got busy=%b done=%b wr=%b lo=%h hi=%h, expected all 0",
               busy, done, wr_muldiv, lo, hi);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    nChecks++;
    if (pulses != 0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_no_done: got %0d done pulses, expected 0", pulses);
    end
    refModel(2'b00, 32'h00001234, 32'h00005678, eLo, eHi, eDz, eLat);
    runOp(2'b00, 32'h00001234, 32'h00005678, edges, gotDone, busyOk);
    nChecks++;
    if (!gotDone || edges != eLat || {lo, hi, div_zero} !== {eLo, eHi, eDz}) begin
      nFails++;
      $display("[TB] FAIL reset_mid_recover: got edges=%0d lo=%h hi=%h dz=%b, expected edges=%0d lo=%h hi=%h dz=%b",
               edges, lo, hi, div_zero, eLat, eLo, eHi, eDz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_back_to_back();
    int          edges;
    logic        gotDone;
    logic        busyOk;
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eLo;
    logic [31:0] eHi;
    logic        eDz;
    int          eLat;
    for (int n = 0; n < 30; n++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = -32'($urandom_range(1, 15));
        default: ;
      endcase
      refModel(o, x, y, eLo, eHi, eDz, eLat);
      runOp(o, x, y, edges, gotDone, busyOk);
      nChecks++;
      if (!gotDone || edges != eLat || !busyOk) begin
        nFails++;
        $display("[TB] FAIL rand%0d_timing: got edges=%0d done=%b busyOk=%b, expected edges=%0d", n, edges, gotDone, busyOk, eLat);
      end
      nChecks++;
      if ({lo, hi, div_zero} !== {eLo, eHi, eDz}) begin
        nFails++;
        $display("[TB] FAIL rand%0d_result op=%0d a=%h b=%h: got lo=%h hi=%h dz=%b, expected lo=%h hi=%h dz=%b",
                 n, o, x, y, lo, hi, div_zero, eLo, eHi, eDz);
      end
      @(posedge clk);
      #1;
      nChecks++;
      if ({done, wr_muldiv} !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL rand%0d_pulse_width: got done=%b wr=%b, expected 0 0", n, done, wr_muldiv);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #2 rst = 1'b1;
    #10;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
